// File: rtl/mips_dmem_responder_if.sv
// Load/store request/response bundle between the mips core data port and its memory responder.
// rsp_err is only present when MIPS_DMEM_FAULT_EN is defined.
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
`ifdef MIPS_DMEM_FAULT_EN
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif
endinterface

// File: rtl/mips_dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states for the mips core.
// Optional MIPS_DMEM_FAULT_EN adds range/alignment fault detection and the rsp_err output.
module mips_dmem_responder #(
    parameter int unsigned DepthWords = 1024,
    parameter int unsigned WaitCycles = 2,
    parameter logic [31:0] BaseAddr   = 32'h1001_0000
) (
    input logic                   clock_i,
    input logic                   reset_ni,
    mips_dmem_responder_if.slave  bus
);
    localparam int unsigned Aw = $clog2(DepthWords);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem_q [DepthWords];

    logic          accept;
    logic          enter_resp;
    logic          fault;
    logic          wr_en;
    logic          eff_we;
    logic [3:0]    eff_be;
    logic [31:0]   eff_addr, eff_wdata;
    logic [Aw-1:0] mem_idx;

    assign accept = bus.req_valid & req_ready_q;

    // With zero wait states the response edge is the accept edge, so use the live bus fields.
    assign eff_we    = accept ? bus.req_we    : we_q;
    assign eff_be    = accept ? bus.req_be    : be_q;
    assign eff_addr  = accept ? bus.req_addr  : addr_q;
    assign eff_wdata = accept ? bus.req_wdata : wdata_q;
    assign mem_idx   = Aw'((eff_addr - BaseAddr) >> 2);

`ifdef MIPS_DMEM_FAULT_EN
    logic [31:0] offset;
    assign offset = eff_addr - BaseAddr;
    assign fault  = ((offset >> (Aw + 2)) != 32'd0) ||
                    ((eff_addr[1:0] != 2'b00) && (eff_be == 4'hF));
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WaitCycles == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WaitCycles - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = (state_d == StResp);
    assign wr_en      = enter_resp & eff_we & ~fault;

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        if (enter_resp) rsp_rdata_d = (eff_we | fault) ? 32'd0 : mem_q[mem_idx];
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == StIdle);
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= enter_resp & fault;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                we_q    <= bus.req_we;
                be_q    <= bus.req_be;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clock_i) begin
        if (reset_ni && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) mem_q[mem_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef MIPS_DMEM_FAULT_EN
    assign bus.rsp_err   = rsp_err_q;
`endif

endmodule
